// File: rtl/pic16_periph_pkg.sv
// Shared constants and small helpers for the PIC16 peripheral blocks.
package pic16_periph_pkg;

  localparam int unsigned RB_INT_BIT                = 0;
  localparam logic [7:0]  PORTB_CHANGE_MASK_DEFAULT = 8'hF0;
  localparam int unsigned SYNC_STAGES_DEFAULT       = 2;

  // Edge of the selected polarity between two consecutive levels.
  function automatic logic edge_hit(input logic cur, input logic old, input logic rising);
    return rising ? (cur & ~old) : (~cur & old);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Per-bit flop chain used to bring asynchronous pins into the clk domain.
module sync_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/portb_int_detect.sv
// PORTB input conditioning: pin synchroniser, RB0/INT edge flag and RB<7:4> change flag.
// Optional RB0 glitch filter enabled by defining PORTB_INT_GLITCH_FILTER_EN.
module portb_int_detect
  import pic16_periph_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic [WIDTH-1:0] CHANGE_MASK = WIDTH'(PORTB_CHANGE_MASK_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] tris,
  input  logic             intedg,
  input  logic             port_rd,
  input  logic             intf_clr,
  input  logic             rbif_clr,
  output logic [WIDTH-1:0] sync_out,
  output logic             intf,
  output logic             rbif
);

  logic             prev0_q, prev0_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             intf_q, intf_d;
  logic             rbif_q, rbif_d;
  logic             lvl_cur_c, lvl_old_c;
  logic             int_edge_c;
  logic             mismatch_c;

  sync_chain #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (pin_in),
    .dout(sync_out)
  );

`ifdef PORTB_INT_GLITCH_FILTER_EN
  logic f0_q, f0_d;

  // Filtered level follows sync only after two agreeing samples; its update is the edge.
  always_comb begin
    f0_d = f0_q;
    if ((sync_out[RB_INT_BIT] == prev0_q) && (sync_out[RB_INT_BIT] != f0_q)) begin
      f0_d = sync_out[RB_INT_BIT];
    end
    lvl_cur_c = f0_d;
    lvl_old_c = f0_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f0_q <= 1'b0;
    end else begin
      f0_q <= f0_d;
    end
  end
`else
  always_comb begin
    lvl_cur_c = sync_out[RB_INT_BIT];
    lvl_old_c = prev0_q;
  end
`endif

  // Flag sets take priority over CPU clears; mismatch uses the pre-read snapshot.
  always_comb begin
    prev0_d    = sync_out[RB_INT_BIT];
    snap_d     = snap_q;
    int_edge_c = edge_hit(lvl_cur_c, lvl_old_c, intedg);
    mismatch_c = |((sync_out ^ snap_q) & CHANGE_MASK & tris);
    if (port_rd) begin
      snap_d = sync_out;
    end
    intf_d = int_edge_c | (intf_q & ~intf_clr);
    rbif_d = mismatch_c | (rbif_q & ~rbif_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev0_q <= 1'b0;
      snap_q  <= '0;
      intf_q  <= 1'b0;
      rbif_q  <= 1'b0;
    end else begin
      prev0_q <= prev0_d;
      snap_q  <= snap_d;
      intf_q  <= intf_d;
      rbif_q  <= rbif_d;
    end
  end

  assign intf = intf_q;
  assign rbif = rbif_q;

endmodule
